d_latch_bank_arbiter: RTL and testbench

Arbitrates write access from N_REQ requesters to one shared W-bit bank of gated D latches (data input D, level enable E). Each granted write drives the latch bank through a fixed setup / enable / hold sequence so D is stable across the whole E-high window. The block sits between the clocked requester logic and the asynchronous latch bank, and is the only driver of the bank's D and E inputs.

---
 rtl/d_latch_ctrl_pkg.sv | 13 +
 rtl/rr_priority_picker.sv | 31 +++
 rtl/d_latch_bank_arbiter.sv | 141 ++++++++++++++
 tb/tb_d_latch_bank_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/d_latch_ctrl_pkg.sv
// Shared types for the latch bank write controller: FSM state encoding.
package d_latch_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ENABLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational requester picker: first set REQ bit at or above start_ptr, wrapping.
// A start_ptr of zero gives plain lowest-index-wins priority.
module rr_priority_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start_ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [IDX_W-1:0] win_idx
);

    logic found;
    int   idx;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(start_ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found       = 1'b1;
                win_oh[idx] = 1'b1;
                win_idx     = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/d_latch_bank_arbiter.sv
// Arbitrates N_REQ writers onto one gated-D latch bank with a setup/enable/hold sequence.
// Optional ROUND_ROBIN_EN macro: rotating priority; undefined gives fixed lowest-index priority.
//
// state  | meaning
// IDLE   | arbitrate; on any REQ capture winner's word and grant
// SETUP  | D stable, E low
// ENABLE | E high for EN_CYCLES cycles
// HOLD   | E low, D held, ACK to winner
module d_latch_bank_arbiter
    import d_latch_ctrl_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int EN_CYCLES = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N_REQ-1:0]       REQ,
    input  logic [N_REQ*WIDTH-1:0] DATA,
    output logic [N_REQ-1:0]       GNT,
    output logic [N_REQ-1:0]       ACK,
    output logic                   BUSY,
    output logic [WIDTH-1:0]       LATCH_D,
    output logic                   LATCH_E
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(EN_CYCLES + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] ldata_q, ldata_d;
    logic             len_q, len_d;

    logic [N_REQ-1:0] win_oh;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] start_ptr;

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req       (REQ),
        .start_ptr (start_ptr),
        .win_oh    (win_oh),
        .win_idx   (win_idx)
    );

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    assign start_ptr = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && |REQ) begin
            ptr_d = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`else
    assign start_ptr = '0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        ldata_d = ldata_q;
        len_d   = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (|REQ) begin
                    state_d = SETUP;
                    gnt_d   = win_oh;
                    ldata_d = DATA[int'(win_idx)*WIDTH +: WIDTH];
                end
            end
            SETUP: begin
                state_d = ENABLE;
                len_d   = 1'b1;
                cnt_d   = CNT_W'(EN_CYCLES);
            end
            ENABLE: begin
                // cnt_q == 1 marks the final E-high cycle
                if (cnt_q == CNT_W'(1)) begin
                    state_d = HOLD;
                    ack_d   = gnt_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    len_d = 1'b1;
                end
            end
            HOLD: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            ldata_q <= '0;
            len_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            ldata_q <= ldata_d;
            len_q   <= len_d;
        end
    end

    assign GNT     = gnt_q;
    assign ACK     = ack_q;
    assign BUSY    = busy_q;
    assign LATCH_D = ldata_q;
    assign LATCH_E = len_q;

endmodule

// File: tb/tb_d_latch_bank_arbiter.sv
// Bench for d_latch_bank_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_d_latch_bank_arbiter;

    localparam int N_REQ     = 4;
    localparam int WIDTH     = 8;
    localparam int EN_CYCLES = 2;
    localparam int WRITE_LEN = EN_CYCLES + 3;

    logic                   CLK = 1'b0;
    logic                   RST = 1'b1;
    logic [N_REQ-1:0]       REQ = '0;
    logic [N_REQ*WIDTH-1:0] DATA = '0;
    logic [N_REQ-1:0]       GNT;
    logic [N_REQ-1:0]       ACK;
    logic                   BUSY;
    logic [WIDTH-1:0]       LATCH_D;
    logic                   LATCH_E;

    d_latch_bank_arbiter #(
        .N_REQ     (N_REQ),
        .WIDTH     (WIDTH),
        .EN_CYCLES (EN_CYCLES)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .DATA    (DATA),
        .GNT     (GNT),
        .ACK     (ACK),
        .BUSY    (BUSY),
        .LATCH_D (LATCH_D),
        .LATCH_E (LATCH_E)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_bad   = 0;

    // Transaction model: a write is "age" cycles old since its grant edge.
    bit             m_busy = 0;
    int             m_age  = 0;
    int             m_win  = 0;
    int             m_ptr  = 0;
    logic [WIDTH-1:0] m_word = '0;

    int cyc_n = 0;
    logic [N_REQ-1:0] prev_gnt = '0;
    int grant_log[$];
    int ack_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    function automatic int oh_to_idx(input logic [N_REQ-1:0] oh);
        int r = -1;
        for (int i = 0; i < N_REQ; i++) if (oh[i]) r = i;
        return r;
    endfunction

    task automatic model_step();
        bit found;
        int idx;
        if (RST) begin
            m_busy = 0; m_age = 0; m_win = 0; m_ptr = 0; m_word = '0;
        end else if (m_busy) begin
            m_age++;
            if (m_age == EN_CYCLES + 2) m_busy = 0;
        end else if (REQ != 0) begin
            found = 0;
            for (int k = 0; k < N_REQ; k++) begin
                idx = (m_ptr + k) % N_REQ;
                if (!found && REQ[idx]) begin
                    found = 1;
                    m_win = idx;
                end
            end
            m_busy = 1;
            m_age  = 0;
            m_word = DATA[m_win*WIDTH +: WIDTH];
`ifdef ROUND_ROBIN_EN
            m_ptr = (m_win + 1) % N_REQ;
`endif
        end
    endtask

    task automatic model_check();
        logic [N_REQ-1:0] e_gnt, e_ack;
        logic             e_len;
        e_gnt = m_busy ? N_REQ'(1 << m_win) : '0;
        e_ack = (m_busy && m_age == EN_CYCLES + 1) ? N_REQ'(1 << m_win) : '0;
        e_len = m_busy && m_age >= 1 && m_age <= EN_CYCLES;
        chk("gnt",     64'(GNT),     64'(e_gnt));
        chk("ack",     64'(ACK),     64'(e_ack));
        chk("busy",    64'(BUSY),    64'(m_busy));
        chk("latch_e", 64'(LATCH_E), 64'(e_len));
        chk("latch_d", 64'(LATCH_D), 64'(m_word));
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_step();
        #1;
        cyc_n++;
        model_check();
        if (GNT != 0 && prev_gnt == 0) grant_log.push_back(oh_to_idx(GNT));
        if (ACK != 0) ack_log.push_back(cyc_n);
        prev_gnt = GNT;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        REQ = '0;
        cyc();
        cyc();
        RST = 1'b0;
        grant_log.delete();
        ack_log.delete();
    endtask

    int exp_rr[5];
    int exp_pair[3];

    initial begin
`ifdef ROUND_ROBIN_EN
        exp_rr   = '{0, 1, 2, 3, 0};
        exp_pair = '{1, 2, 1};
`else
        exp_rr   = '{0, 0, 0, 0, 0};
        exp_pair = '{1, 1, 1};
`endif
        do_reset();
        chk("rst_busy", 64'(BUSY), 64'(0));
        chk("rst_gnt",  64'(GNT),  64'(0));

        // single write of 0xA5 from requester 0
        DATA = '0;
        DATA[7:0] = 8'hA5;
        REQ = 4'b0001;
        cyc();
        chk("t1_gnt", 64'(GNT), 64'(4'b0001));
        chk("t1_d",   64'(LATCH_D), 64'(8'hA5));
        chk("t1_e0",  64'(LATCH_E), 64'(0));
        cyc();
        chk("t1_e1",  64'(LATCH_E), 64'(1));
        cyc();
        chk("t1_e2",  64'(LATCH_E), 64'(1));
        cyc();
        chk("t1_ack", 64'(ACK), 64'(4'b0001));
        chk("t1_e3",  64'(LATCH_E), 64'(0));
        REQ = '0;
        cyc();
        chk("t1_idle", 64'(BUSY), 64'(0));
        chk("t1_keep", 64'(LATCH_D), 64'(8'hA5));

        // all four requesting continuously
        do_reset();
        REQ = 4'b1111;
        for (int i = 0; i < 5 * WRITE_LEN - 2; i++) cyc();
        chk("t2_ngnt", 64'(grant_log.size() >= 5), 64'(1));
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            chk($sformatf("t2_order%0d", i), 64'(grant_log[i]), 64'(exp_rr[i]));
        for (int i = 0; i + 1 < ack_log.size(); i++)
            chk($sformatf("t2_ackgap%0d", i), 64'(ack_log[i+1] - ack_log[i]), 64'(WRITE_LEN));

        // requesters 1 and 2 contending
        do_reset();
        REQ = 4'b0110;
        for (int i = 0; i < 3 * WRITE_LEN; i++) cyc();
        chk("t3_ngnt", 64'(grant_log.size() >= 3), 64'(1));
        for (int i = 0; i < 3 && i < grant_log.size(); i++)
            chk($sformatf("t3_order%0d", i), 64'(grant_log[i]), 64'(exp_pair[i]));

        // DATA changes during ENABLE must not reach the bank
        do_reset();
        DATA[7:0] = 8'h3C;
        REQ = 4'b0001;
        cyc();
        cyc();
        DATA[7:0] = 8'hFF;
        cyc();
        chk("t4_e", 64'(LATCH_E), 64'(1));
        chk("t4_d", 64'(LATCH_D), 64'(8'h3C));
        cyc();
        chk("t4_d_hold", 64'(LATCH_D), 64'(8'h3C));
        REQ = '0;
        for (int i = 0; i < 3; i++) cyc();

        // reset in first ENABLE cycle aborts without ACK
        do_reset();
        DATA[7:0] = 8'h5A;
        REQ = 4'b0001;
        cyc();
        cyc();
        chk("t5_e_before", 64'(LATCH_E), 64'(1));
        RST = 1'b1;
        REQ = '0;
        cyc();
        chk("t5_e",    64'(LATCH_E), 64'(0));
        chk("t5_gnt",  64'(GNT),     64'(0));
        chk("t5_d",    64'(LATCH_D), 64'(0));
        chk("t5_busy", 64'(BUSY),    64'(0));
        RST = 1'b0;
        for (int i = 0; i < WRITE_LEN; i++) cyc();
        chk("t5_noack", 64'(ack_log.size()), 64'(0));

        // requester 2 drops REQ in SETUP
        do_reset();
        REQ = 4'b0100;
        cyc();
        REQ = '0;
        cyc();
        cyc();
        cyc();
        chk("t6_ack", 64'(ACK), 64'(4'b0100));
        cyc();
        chk("t6_idle", 64'(BUSY), 64'(0));

        // random traffic with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            REQ  = N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
            DATA = {$urandom};
            RST  = ($urandom_range(0, 199) == 0);
            cyc();
        end
        RST = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
